// File: rtl/iq_integrate_dump.sv
// rtl/iq_integrate_dump.sv - symbol-rate I/Q integrate-and-dump with scaling, saturation and SYNC realignment
//
// Sums SPS matched I/Q samples per symbol, shifts the sums right by OUT_SHIFT,
// clamps them to O_WIDTH and emits one registered I/Q pair per symbol.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   I_tdata/I_tvalid         signed in-phase sample stream
//   Q_tdata/Q_tvalid         signed quadrature sample stream
//   SYNC                     symbol-boundary strobe from timing recovery
//   SYM_I_tdata/SYM_Q_tdata  integrated, scaled, saturated symbol (held between pulses)
//   SYM_tvalid               one-cycle pulse per symbol
//   SAT                      pulses with SYM_tvalid when either channel clamped
//   ALIGN_ERR                sticky flag, I_tvalid and Q_tvalid disagreed
//   DROP                     one-cycle pulse when SYNC discarded a partial window

module iq_integrate_dump #(
    parameter int I_WIDTH   = 16,
    parameter int O_WIDTH   = 16,
    parameter int ACC_WIDTH = 24,
    parameter int SPS       = 8,
    parameter int OUT_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [I_WIDTH-1:0] I_tdata,
    input  logic               I_tvalid,
    input  logic [I_WIDTH-1:0] Q_tdata,
    input  logic               Q_tvalid,
    input  logic               SYNC,
    output logic [O_WIDTH-1:0] SYM_I_tdata,
    output logic [O_WIDTH-1:0] SYM_Q_tdata,
    output logic               SYM_tvalid,
    output logic               SAT,
    output logic               ALIGN_ERR,
    output logic               DROP
);

    localparam int CNT_W = $clog2(SPS);

    if (SPS < 2) begin : g_bad_sps
        $error("iq_integrate_dump: SPS must be at least 2");
    end
    if (ACC_WIDTH < I_WIDTH + $clog2(SPS)) begin : g_bad_acc
        $error("iq_integrate_dump: ACC_WIDTH too small for I_WIDTH and SPS");
    end
    if (ACC_WIDTH < O_WIDTH) begin : g_bad_out
        $error("iq_integrate_dump: ACC_WIDTH must be at least O_WIDTH");
    end

    // Clamp limits expressed one bit wider than the accumulator so the
    // comparison is always signed and never overflows.
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH - O_WIDTH + 2){1'b0}}, {(O_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH - O_WIDTH + 2){1'b1}}, {(O_WIDTH - 1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_WIDTH-1:0] acc_q_q, acc_q_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [O_WIDTH-1:0]          sym_i_q, sym_i_d;
    logic [O_WIDTH-1:0]          sym_q_q, sym_q_d;
    logic                        sym_tvalid_q, sym_tvalid_d;
    logic                        sat_q, sat_d;
    logic                        align_err_q, align_err_d;
    logic                        drop_q, drop_d;

    logic                        accept;
    logic                        last;
    logic signed [ACC_WIDTH-1:0] samp_i_ext, samp_q_ext;
    logic signed [ACC_WIDTH-1:0] sum_i, sum_q;
    logic [O_WIDTH:0]            res_i, res_q;

    // Returns {clamped, value}: arithmetic shift then clamp to O_WIDTH.
    function automatic logic [O_WIDTH:0] scale_sat(input logic signed [ACC_WIDTH-1:0] s);
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] r;
        ext = {s[ACC_WIDTH-1], s};
        r   = ext >>> OUT_SHIFT;
        if (r > SAT_MAX) begin
            scale_sat = {1'b1, SAT_MAX[O_WIDTH-1:0]};
        end else if (r < SAT_MIN) begin
            scale_sat = {1'b1, SAT_MIN[O_WIDTH-1:0]};
        end else begin
            scale_sat = {1'b0, r[O_WIDTH-1:0]};
        end
    endfunction

    assign accept     = I_tvalid & Q_tvalid;
    assign last       = (cnt_q == CNT_W'(SPS - 1));
    assign samp_i_ext = {{(ACC_WIDTH - I_WIDTH){I_tdata[I_WIDTH-1]}}, I_tdata};
    assign samp_q_ext = {{(ACC_WIDTH - I_WIDTH){Q_tdata[I_WIDTH-1]}}, Q_tdata};
    assign sum_i      = acc_i_q + samp_i_ext;
    assign sum_q      = acc_q_q + samp_q_ext;
    assign res_i      = scale_sat(sum_i);
    assign res_q      = scale_sat(sum_q);

    always_comb begin
        acc_i_d      = acc_i_q;
        acc_q_d      = acc_q_q;
        cnt_d        = cnt_q;
        sym_i_d      = sym_i_q;
        sym_q_d      = sym_q_q;
        sym_tvalid_d = 1'b0;
        sat_d        = 1'b0;
        drop_d       = 1'b0;
        align_err_d  = align_err_q | (I_tvalid ^ Q_tvalid);

        // SYNC wins over window completion: a full window coinciding with
        // SYNC is discarded and the incoming sample opens the new window.
        if (SYNC) begin
            drop_d = (cnt_q != '0);
            if (accept) begin
                acc_i_d = samp_i_ext;
                acc_q_d = samp_q_ext;
                cnt_d   = CNT_W'(1);
            end else begin
                acc_i_d = '0;
                acc_q_d = '0;
                cnt_d   = '0;
            end
        end else if (accept) begin
            if (last) begin
                acc_i_d      = '0;
                acc_q_d      = '0;
                cnt_d        = '0;
                sym_i_d      = res_i[O_WIDTH-1:0];
                sym_q_d      = res_q[O_WIDTH-1:0];
                sym_tvalid_d = 1'b1;
                sat_d        = res_i[O_WIDTH] | res_q[O_WIDTH];
            end else begin
                acc_i_d = sum_i;
                acc_q_d = sum_q;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_i_q      <= '0;
            acc_q_q      <= '0;
            cnt_q        <= '0;
            sym_i_q      <= '0;
            sym_q_q      <= '0;
            sym_tvalid_q <= 1'b0;
            sat_q        <= 1'b0;
            align_err_q  <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            acc_i_q      <= acc_i_d;
            acc_q_q      <= acc_q_d;
            cnt_q        <= cnt_d;
            sym_i_q      <= sym_i_d;
            sym_q_q      <= sym_q_d;
            sym_tvalid_q <= sym_tvalid_d;
            sat_q        <= sat_d;
            align_err_q  <= align_err_d;
            drop_q       <= drop_d;
        end
    end

    assign SYM_I_tdata = sym_i_q;
    assign SYM_Q_tdata = sym_q_q;
    assign SYM_tvalid  = sym_tvalid_q;
    assign SAT         = sat_q;
    assign ALIGN_ERR   = align_err_q;
    assign DROP        = drop_q;

endmodule

// File: tb/tb_iq_integrate_dump.sv
// tb/tb_iq_integrate_dump.sv - scoreboard bench for iq_integrate_dump
module tb_iq_integrate_dump;

    localparam int SPS = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] I_tdata = '0;
    logic               I_tvalid = 1'b0;
    logic signed [15:0] Q_tdata = '0;
    logic               Q_tvalid = 1'b0;
    logic               SYNC = 1'b0;
    logic signed [15:0] SYM_I_tdata;
    logic signed [15:0] SYM_Q_tdata;
    logic               SYM_tvalid;
    logic               SAT;
    logic               ALIGN_ERR;
    logic               DROP;

    iq_integrate_dump dut (
        .clk(clk), .rst(rst),
        .I_tdata(I_tdata), .I_tvalid(I_tvalid),
        .Q_tdata(Q_tdata), .Q_tvalid(Q_tvalid),
        .SYNC(SYNC),
        .SYM_I_tdata(SYM_I_tdata), .SYM_Q_tdata(SYM_Q_tdata),
        .SYM_tvalid(SYM_tvalid), .SAT(SAT),
        .ALIGN_ERR(ALIGN_ERR), .DROP(DROP)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int q;
        int sat;
    } sym_t;

    sym_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   m_acc_i, m_acc_q, m_cnt, m_align;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp16(input int v, output int sat);
        sat = 0;
        if (v > 32767)  begin sat = 1; return 32767;  end
        if (v < -32768) begin sat = 1; return -32768; end
        return v;
    endfunction

    task automatic model_clear();
        m_acc_i = 0; m_acc_q = 0; m_cnt = 0; m_align = 0;
    endtask

    // Drive one cycle, predict, then check the registered outputs after the edge.
    task automatic step(input bit iv, input bit qv, input int si, input int sq, input bit sy);
        bit   exp_valid, exp_drop;
        sym_t e, got;
        int   si_, sq_;
        I_tvalid = iv; Q_tvalid = qv; SYNC = sy;
        I_tdata = 16'(si); Q_tdata = 16'(sq);
        exp_valid = 0; exp_drop = 0;
        if (iv != qv) m_align = 1;
        if (sy) begin
            exp_drop = (m_cnt != 0);
            if (iv && qv) begin m_acc_i = si; m_acc_q = sq; m_cnt = 1; end
            else          begin m_acc_i = 0;  m_acc_q = 0;  m_cnt = 0; end
        end else if (iv && qv) begin
            m_acc_i += si; m_acc_q += sq;
            if (m_cnt == SPS - 1) begin
                e.i = clamp16(m_acc_i >>> 2, si_);
                e.q = clamp16(m_acc_q >>> 2, sq_);
                e.sat = si_ | sq_;
                sb.push_back(e);
                exp_valid = 1;
                m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        check("sym_tvalid", int'(SYM_tvalid), int'(exp_valid));
        check("drop", int'(DROP), int'(exp_drop));
        check("align_err", int'(ALIGN_ERR), m_align);
        if (SYM_tvalid) begin
            if (sb.size() == 0) begin
                check("unexpected_symbol", 1, 0);
            end else begin
                got = sb.pop_front();
                check("sym_i", int'(SYM_I_tdata), got.i);
                check("sym_q", int'(SYM_Q_tdata), got.q);
                check("sat", int'(SAT), got.sat);
            end
        end else begin
            check("sat_idle", int'(SAT), 0);
        end
        @(negedge clk);
        I_tvalid = 0; Q_tvalid = 0; SYNC = 0;
    endtask

    task automatic samples(input int n, input int si, input int sq, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) step(0, 0, 0, 0, 0);
            step(1, 1, si, sq, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sym_i"}, int'(SYM_I_tdata), 0);
        check({tag, "_sym_q"}, int'(SYM_Q_tdata), 0);
        check({tag, "_tvalid"}, int'(SYM_tvalid), 0);
        check({tag, "_sat"}, int'(SAT), 0);
        check({tag, "_align"}, int'(ALIGN_ERR), 0);
        check({tag, "_drop"}, int'(DROP), 0);
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 0;
        @(negedge clk);

        // Basic window: 8*100>>2 = 200.
        samples(8, 100, -100, 0);
        // Saturation both rails, then zeros.
        samples(8, 20000, -20000, 0);
        samples(8, 0, 0, 0);
        // SYNC after a 5-sample partial window.
        samples(5, 50, 50, 0);
        step(1, 1, 10, 10, 1);
        samples(7, 10, 10, 0);
        // SYNC coinciding with the 8th sample.
        samples(7, 1, 1, 0);
        step(1, 1, 1000, -1000, 1);
        samples(7, 1000, -1000, 0);
        // SYNC at a window boundary: no DROP, with and without a sample.
        step(0, 0, 0, 0, 1);
        step(1, 1, 3, 3, 1);
        samples(7, 3, 3, 0);
        // Mismatched valids inside a window.
        samples(3, 40, 40, 0);
        step(1, 0, 999, 999, 0);
        step(0, 1, 999, 999, 0);
        samples(5, 40, 40, 0);
        // Floor toward minus infinity on negative sums.
        samples(8, -1, -1, 0);
        samples(8, -3, 5, 1);

        // Asynchronous reset mid-window.
        samples(4, 123, -77, 0);
        #2 rst = 1;
        #1 check_all_zero("async_rst");
        check("sb_empty_at_rst", sb.size(), 0);
        model_clear();
        @(negedge clk);
        rst = 0;
        samples(8, 4, 4, 1);

        // Random windows with random gaps.
        for (int w = 0; w < 6; w++) begin
            for (int k = 0; k < SPS; k++) begin
                if ($urandom_range(0, 2) == 0) step(0, 0, 0, 0, 0);
                step(1, 1, int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 65535)) - 32768, 0);
            end
        end
        step(0, 0, 0, 0, 0);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
